// File: rtl/cdc_handshake_tx_if.sv
// Source-side bundle of the 4-phase req/ack CDC transmitter.
// master is the transmitter; slave is whatever drives words in and returns ack.
interface cdc_handshake_tx_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             src_valid;
   logic [WIDTH-1:0] src_data;
   logic             src_ready;
   logic             req_out;
   logic [WIDTH-1:0] data_out;
   logic             ack_in;
   logic             done;

   modport master (
      input  src_valid,
      input  src_data,
      input  ack_in,
      output src_ready,
      output req_out,
      output data_out,
      output done
   );

   modport slave (
      output src_valid,
      output src_data,
      output ack_in,
      input  src_ready,
      input  req_out,
      input  data_out,
      input  done
   );

endinterface

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack handshake: holds one word on data_out while req_out
// is raised, and resynchronizes the returning ack through a SYNC_STAGES flop chain.
module cdc_handshake_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   cdc_handshake_tx_if.master        bus
);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRelease
   } state_e;

   state_e                 state_q;
   logic                   req_q;
   logic [WIDTH-1:0]       data_q;
   logic                   done_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   src_ready;
   logic                   accept;

   // ack_in feeds only the first flop of the chain; everything else sees ack_s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   // A lingering ack from a previous or aborted transfer blocks new accepts.
   assign src_ready = (state_q == StIdle) && !ack_s;
   assign accept    = bus.src_valid && src_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  data_q  <= bus.src_data;
                  req_q   <= 1'b1;
                  state_q <= StReq;
               end
            end
            StReq: begin
               if (ack_s) begin
                  req_q   <= 1'b0;
                  state_q <= StRelease;
               end
            end
            StRelease: begin
               if (!ack_s) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.src_ready = src_ready;
   assign bus.req_out   = req_q;
   assign bus.data_out  = data_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: stimulus pushes expected transfers, a negedge
// monitor pops them on done and checks req timing and data_out hold.
module tb_cdc_handshake_tx;

   localparam int unsigned W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic loop_en;
   logic ack_man;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cdc_handshake_tx_if #(.WIDTH(W)) bus ();
   cdc_handshake_tx_if #(.WIDTH(W)) bus3 ();

   assign bus.ack_in  = loop_en ? bus.req_out : ack_man;
   assign bus3.ack_in = bus3.req_out;

   cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   typedef struct {
      int data;
      int rise;
      int fall;
      int done_c;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_neg(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic send(input logic [7:0] d, output int acc);
      int waited;
      waited = 0;
      acc    = -1;
      bus.src_valid = 1'b1;
      bus.src_data  = d;
      while (acc < 0 && waited < 50) begin
         @(negedge clk);
         if (bus.src_ready) acc = cyc;
         else waited++;
      end
      if (acc < 0) check("accept_timeout", waited, 0);
      @(posedge clk);
      #1;
      bus.src_valid = 1'b0;
   endtask

   task automatic push_loop(input logic [7:0] d, input int acc);
      exp_t e;
      e.data   = int'(d);
      e.rise   = acc + 1;
      e.fall   = acc + 4;
      e.done_c = acc + 7;
      exp_q.push_back(e);
   endtask

   // Monitor: req edges and done pulses are compared against the head of the queue.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (bus.req_out && !prev_req) begin
            if (exp_q.size() == 0) check("req_rise_expected", exp_q.size(), 1);
            else begin
               check("req_rise_cycle", cyc, exp_q[0].rise);
               check("data_at_req", int'(bus.data_out), exp_q[0].data);
            end
         end
         if (!bus.req_out && prev_req) begin
            if (exp_q.size() == 0) check("req_fall_expected", exp_q.size(), 1);
            else check("req_fall_cycle", cyc, exp_q[0].fall);
         end
         if (exp_q.size() != 0 && cyc > exp_q[0].rise)
            check("data_hold", int'(bus.data_out), exp_q[0].data);
         if (bus.done) begin
            if (exp_q.size() == 0) check("done_expected", exp_q.size(), 1);
            else begin
               check("done_cycle", cyc, exp_q[0].done_c);
               void'(exp_q.pop_front());
            end
         end
         prev_req = bus.req_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a2, a3, s, r, p;
      int acc3[$];
      int runs[$];
      int run;

      bus.src_valid  = 1'b0;
      bus.src_data   = '0;
      bus3.src_valid = 1'b0;
      bus3.src_data  = '0;
      loop_en        = 1'b1;
      ack_man        = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #11;
      check("rst_req", int'(bus.req_out), 0);
      check("rst_data", int'(bus.data_out), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_ready", int'(bus.src_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cycles(2);

      // T1: single loopback transfer
      s = cyc;
      send(8'hA5, a);
      push_loop(8'hA5, a);
      check("t1_accept_cycle0", a, s);
      at_neg(a + 6);
      check("t1_ready_c6", int'(bus.src_ready), 0);
      at_neg(a + 7);
      check("t1_ready_c7", int'(bus.src_ready), 1);
      check("t1_done_c7", int'(bus.done), 1);
      @(posedge clk);
      #1;

      // T2: back-to-back words with valid held
      send(8'h01, a1);
      push_loop(8'h01, a1);
      send(8'h02, a2);
      push_loop(8'h02, a2);
      check("t2_period_1_2", a2 - a1, 7);
      send(8'h03, a3);
      push_loop(8'h03, a3);
      check("t2_period_2_3", a3 - a2, 7);
      at_neg(a3 + 7);
      @(posedge clk);
      #1;

      // T3: late ack from destination
      loop_en = 1'b0;
      ack_man = 1'b0;
      send(8'h3C, a);
      begin
         exp_t e;
         e.data = 'h3C; e.rise = a + 1; e.fall = a + 14; e.done_c = a + 22;
         exp_q.push_back(e);
      end
      wait_cycles(10);
      ack_man = 1'b1;
      wait_cycles(8);
      ack_man = 1'b0;
      at_neg(a + 21);
      check("t3_no_early_done", int'(bus.done), 0);
      at_neg(a + 22);
      check("t3_done", int'(bus.done), 1);
      @(posedge clk);
      #1;

      // T4: reset mid-transfer with ack high
      loop_en = 1'b1;
      send(8'h5A, a);
      push_loop(8'h5A, a);
      wait_cycles(1);
      check("t4_req_before_rst", int'(bus.req_out), 1);
      ack_man = 1'b1;
      loop_en = 1'b0;
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("t4_req_async", int'(bus.req_out), 0);
      check("t4_data_async", int'(bus.data_out), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      r = cyc;
      for (int c = r + 2; c <= r + 6; c++) begin
         if (c == r + 4) begin
            @(posedge clk);
            #1;
            ack_man = 1'b0;
         end
         at_neg(c);
         check("t4_ready", int'(bus.src_ready), (c >= r + 6) ? 1 : 0);
      end
      check("t4_data_zero", int'(bus.data_out), 0);
      @(posedge clk);
      #1;

      // T5: stray ack pulse while idle
      p = cyc;
      ack_man = 1'b1;
      for (int c = p; c <= p + 7; c++) begin
         if (c == p + 3) begin
            @(posedge clk);
            #1;
            ack_man = 1'b0;
         end
         at_neg(c);
         check("t5_ready", int'(bus.src_ready), (c >= p + 2 && c <= p + 4) ? 0 : 1);
         check("t5_req", int'(bus.req_out), 0);
         check("t5_done", int'(bus.done), 0);
      end
      @(posedge clk);
      #1;

      // T6: SYNC_STAGES = 3 instance with loopback
      bus3.src_valid = 1'b1;
      bus3.src_data  = 8'h77;
      run = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus3.src_valid && bus3.src_ready) acc3.push_back(cyc);
         if (bus3.req_out) run++;
         else if (run > 0) begin
            runs.push_back(run);
            run = 0;
         end
      end
      bus3.src_valid = 1'b0;
      for (int i = 1; i < 3; i++)
         check("t6_period", (i < acc3.size()) ? acc3[i] - acc3[i-1] : -1, 9);
      for (int i = 0; i < 2; i++)
         check("t6_req_len", (i < runs.size()) ? runs[i] : -1, 4);
      check("t6_data", int'(bus3.data_out), 'h77);

      wait_cycles(10);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
